udp_rx_port_router: RTL

//  Sequences the UDP receive datapath. It accepts each UDP header from udp_rx and

---
 rtl/udp_rx_port_router.sv | 114 +++++++++++
 1 files changed

// File: rtl/udp_rx_port_router.sv
// UDP receive port router: matches each header's destination port against the
// configured channel ports, then steers or drains the payload that follows.
module udp_rx_port_router #(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 32
) (
  input  logic                   logic_clk,
  input  logic                   logic_rst,
  input  logic [16*N_PORTS-1:0]  cfg_port,
  input  logic [N_PORTS-1:0]     cfg_en,
  input  logic                   udp_hdr_valid,
  input  logic [15:0]            udp_dest_port,
  input  logic [15:0]            udp_length,
  input  logic [7:0]             udp_payload_axis_tdata,
  input  logic                   udp_payload_axis_tvalid,
  input  logic                   udp_payload_axis_tlast,
  input  logic                   udp_payload_axis_tuser,
  output logic                   udp_rx_ready,
  output logic [7:0]             m_axis_tdata,
  output logic [N_PORTS-1:0]     m_axis_tvalid,
  input  logic [N_PORTS-1:0]     m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [2:0]             m_chan,
  output logic [15:0]            m_udp_length,
  output logic                   busy,
  output logic [CNT_W-1:0]       drop_count,
  output logic [CNT_W-1:0]       stray_count
);

  typedef enum logic [1:0] {IDLE, MATCH, FWD, DROP} state_t;

  state_t      state, state_next;
  logic [15:0] dest_port;
  logic        match_hit;
  logic [2:0]  match_idx;
  logic        has_payload;

  assign m_axis_tdata = udp_payload_axis_tdata;
  assign m_axis_tlast = udp_payload_axis_tlast;
  assign m_axis_tuser = udp_payload_axis_tuser;
  assign busy         = (state != IDLE);
  assign has_payload  = (m_udp_length > 16'd8);

  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (cfg_en[i] && (cfg_port[16*i +: 16] == dest_port)) begin
        match_hit = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next    = state;
    udp_rx_ready  = 1'b0;
    m_axis_tvalid = '0;
    case (state)
      IDLE: begin
        udp_rx_ready = 1'b1;
        if (udp_hdr_valid) state_next = MATCH;
      end
      MATCH: begin
        if (!has_payload)   state_next = IDLE;
        else if (match_hit) state_next = FWD;
        else                state_next = DROP;
      end
      FWD: begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (m_chan == 3'(i)) begin
            udp_rx_ready     = m_axis_tready[i];
            m_axis_tvalid[i] = udp_payload_axis_tvalid;
          end
        end
        if (udp_payload_axis_tvalid && udp_rx_ready && udp_payload_axis_tlast)
          state_next = IDLE;
      end
      DROP: begin
        udp_rx_ready = 1'b1;
        if (udp_payload_axis_tvalid && udp_payload_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state        <= IDLE;
      dest_port    <= '0;
      m_chan       <= '0;
      m_udp_length <= '0;
      drop_count   <= '0;
      stray_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (state == IDLE && udp_hdr_valid) begin
        dest_port    <= udp_dest_port;
        m_udp_length <= udp_length;
      end
      if (state == IDLE && udp_payload_axis_tvalid && (stray_count != '1))
        stray_count <= stray_count + 1'b1;
      if (state == MATCH && has_payload) begin
        if (match_hit)                m_chan     <= match_idx;
        else if (drop_count != '1)    drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
